// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline constants, multiply-window FSM encoding and
// instruction classification helpers for the ID/EX stage.
package mips_pipe_pkg;

    localparam logic [5:0] R_FORMAT = 6'h00;
    localparam logic [5:0] LW       = 6'h23;
    localparam logic [5:0] SW       = 6'h2B;
    localparam logic [5:0] BEQ      = 6'h04;
    localparam logic [5:0] J        = 6'h02;
    localparam logic [5:0] ADDIU    = 6'h09;
    localparam logic [5:0] MADDU    = 6'h1C;

    localparam logic [5:0] MULTU    = 6'h19;
    localparam logic [5:0] MFHI     = 6'h10;
    localparam logic [5:0] MFLO     = 6'h12;

    localparam int MUL_LAT_DEFAULT = 4;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } mul_state_t;

    function automatic logic is_mul(input logic [5:0] opcode, input logic [5:0] funct);
        return ((opcode == R_FORMAT) && (funct == MULTU)) || (opcode == MADDU);
    endfunction

    function automatic logic is_hilo_rd(input logic [5:0] opcode, input logic [5:0] funct);
        return (opcode == R_FORMAT) && ((funct == MFHI) || (funct == MFLO));
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational hazard terms for the ID/EX boundary: load-use and
// HI/LO-unit occupancy. A flush always wins over a stall.
module hazard_detect
    import mips_pipe_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [5:0] id_opcode,
    input  logic [5:0] id_funct,
    input  logic       mul_busy,
    input  logic       flush,
    output logic       stall
);

    logic load_use;
    logic mul_stall;

    assign load_use  = ex_mem_read && (ex_rt != 5'd0) &&
                       ((ex_rt == id_rs) || (ex_rt == id_rt));
    assign mul_stall = mul_busy &&
                       (is_mul(id_opcode, id_funct) || is_hilo_rd(id_opcode, id_funct));
    assign stall     = (load_use || mul_stall) && !flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use and HI/LO interlock.
// The multiply window FSM is built only when MUL_INTERLOCK_EN is defined.
module id_ex_stage
    import mips_pipe_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_RegDst,
    input  logic        id_ALUSrc,
    input  logic        id_MemtoReg,
    input  logic        id_RegWrite,
    input  logic        id_MemRead,
    input  logic        id_MemWrite,
    input  logic        id_Branch,
    input  logic        id_Jump,
    input  logic [1:0]  id_ALUOp,
    input  logic [5:0]  id_opcode,
    input  logic [5:0]  id_funct,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic        flush,
    output logic        ex_RegDst,
    output logic        ex_ALUSrc,
    output logic        ex_MemtoReg,
    output logic        ex_RegWrite,
    output logic        ex_MemRead,
    output logic        ex_MemWrite,
    output logic        ex_Branch,
    output logic        ex_Jump,
    output logic [1:0]  ex_ALUOp,
    output logic [5:0]  ex_opcode,
    output logic [5:0]  ex_funct,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_rd,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [31:0] ex_imm,
    output logic        stall,
    output logic        mul_busy
);

    if ((MUL_LAT < 2) || (MUL_LAT > 15)) begin : g_lat_check
        $error("id_ex_stage: MUL_LAT must be within 2..15");
    end

    logic stall_int;
    logic bubble;

    hazard_detect u_hazard (
        .ex_mem_read (ex_MemRead),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_opcode   (id_opcode),
        .id_funct    (id_funct),
        .mul_busy    (mul_busy),
        .flush       (flush),
        .stall       (stall_int)
    );

    assign stall  = stall_int;
    assign bubble = flush || stall_int;

    // Bubbles clear only the control fields; operand fields simply hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_RegDst   <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_MemtoReg <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_Branch   <= 1'b0;
            ex_Jump     <= 1'b0;
            ex_ALUOp    <= 2'b00;
            ex_opcode   <= 6'd0;
            ex_funct    <= 6'd0;
            ex_rs       <= 5'd0;
            ex_rt       <= 5'd0;
            ex_rd       <= 5'd0;
            ex_rs_data  <= 32'd0;
            ex_rt_data  <= 32'd0;
            ex_imm      <= 32'd0;
        end else if (bubble) begin
            ex_RegDst   <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_MemtoReg <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_Branch   <= 1'b0;
            ex_Jump     <= 1'b0;
            ex_ALUOp    <= 2'b00;
        end else begin
            ex_RegDst   <= id_RegDst;
            ex_ALUSrc   <= id_ALUSrc;
            ex_MemtoReg <= id_MemtoReg;
            ex_RegWrite <= id_RegWrite;
            ex_MemRead  <= id_MemRead;
            ex_MemWrite <= id_MemWrite;
            ex_Branch   <= id_Branch;
            ex_Jump     <= id_Jump;
            ex_ALUOp    <= id_ALUOp;
            ex_opcode   <= id_opcode;
            ex_funct    <= id_funct;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_rd       <= id_rd;
            ex_rs_data  <= id_rs_data;
            ex_rt_data  <= id_rt_data;
            ex_imm      <= id_imm;
        end
    end

`ifdef MUL_INTERLOCK_EN
    localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);

    mul_state_t state;
    mul_state_t state_nxt;
    logic [3:0] mul_cnt;
    logic [3:0] mul_cnt_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RUN;
            mul_cnt <= 4'd0;
        end else begin
            state   <= state_nxt;
            mul_cnt <= mul_cnt_nxt;
        end
    end

    // The window counts down to zero and stays busy through the zero cycle,
    // so the unit is occupied for exactly MUL_LAT cycles. Flush is ignored
    // here: the multiply in flight is older than the branch.
    always_comb begin
        state_nxt   = state;
        mul_cnt_nxt = mul_cnt;
        case (state)
            RUN: begin
                if (!bubble && is_mul(id_opcode, id_funct)) begin
                    state_nxt   = MUL_WAIT;
                    mul_cnt_nxt = MUL_CNT_INIT;
                end
            end
            MUL_WAIT: begin
                if (mul_cnt == 4'd0) begin
                    state_nxt = RUN;
                end else begin
                    mul_cnt_nxt = mul_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt   = RUN;
                mul_cnt_nxt = 4'd0;
            end
        endcase
    end

    assign mul_busy = (state == MUL_WAIT);
`else
    assign mul_busy = 1'b0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage; multiply-window expectations
// follow whether MUL_INTERLOCK_EN is defined for the build.
module tb_id_ex_stage;
    import mips_pipe_pkg::*;

`ifdef MUL_INTERLOCK_EN
    localparam logic MUL_ON = 1'b1;
`else
    localparam logic MUL_ON = 1'b0;
`endif

    typedef struct {
        logic [7:0]  ctrl;   // {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump}
        logic [1:0]  aluop;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
    } instr_t;

    typedef struct {
        logic [65:0] val;
        logic        full;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite;
    logic        id_MemRead, id_MemWrite, id_Branch, id_Jump;
    logic [1:0]  id_ALUOp;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        flush;
    logic        ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite;
    logic        ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump;
    logic [1:0]  ex_ALUOp;
    logic [5:0]  ex_opcode, ex_funct;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
    logic        stall;
    logic        mul_busy;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];
    exp_t cur;

    id_ex_stage #(.MUL_LAT(4)) dut (
        .clk(clk), .rst(rst),
        .id_RegDst(id_RegDst), .id_ALUSrc(id_ALUSrc), .id_MemtoReg(id_MemtoReg),
        .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
        .id_Branch(id_Branch), .id_Jump(id_Jump), .id_ALUOp(id_ALUOp),
        .id_opcode(id_opcode), .id_funct(id_funct),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .flush(flush),
        .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_MemtoReg(ex_MemtoReg),
        .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_Branch(ex_Branch), .ex_Jump(ex_Jump), .ex_ALUOp(ex_ALUOp),
        .ex_opcode(ex_opcode), .ex_funct(ex_funct),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .stall(stall), .mul_busy(mul_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic instr_t mk(input logic [7:0] ctrl, input logic [1:0] aluop,
                                  input logic [5:0] op, input logic [5:0] fn,
                                  input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd, input logic [31:0] d);
        instr_t i;
        i.ctrl = ctrl;  i.aluop = aluop; i.opcode = op; i.funct = fn;
        i.rs = rs; i.rt = rt; i.rd = rd;
        i.rs_data = d; i.rt_data = ~d; i.imm = d ^ 32'h0000_5A5A;
        return i;
    endfunction

    function automatic logic [65:0] pack(input logic st, input logic bz, input instr_t e);
        return {st, bz, e.ctrl, e.aluop, e.rd, e.rt, e.opcode, e.funct, e.rs_data};
    endfunction

    function automatic logic [65:0] actual();
        return {stall, mul_busy,
                ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite,
                ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump,
                ex_ALUOp, ex_rd, ex_rt, ex_opcode, ex_funct, ex_rs_data};
    endfunction

    task automatic drive(input instr_t i, input logic fl);
        {id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite,
         id_MemRead, id_MemWrite, id_Branch, id_Jump} = i.ctrl;
        id_ALUOp   = i.aluop;
        id_opcode  = i.opcode;
        id_funct   = i.funct;
        id_rs      = i.rs;
        id_rt      = i.rt;
        id_rd      = i.rd;
        id_rs_data = i.rs_data;
        id_rt_data = i.rt_data;
        id_imm     = i.imm;
        flush      = fl;
    endtask

    // One cycle: drive ID just after the edge and queue what the monitor
    // must see at the following falling edge. full=0 checks only
    // stall/mul_busy/control fields (bubble operand fields are don't-care).
    task automatic step(input string nm, input instr_t id, input logic fl,
                        input logic st, input logic bz, input instr_t ex,
                        input logic full);
        exp_t e;
        @(posedge clk);
        #1;
        drive(id, fl);
        e.val  = pack(st, bz, ex);
        e.full = full;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic check_now(input string nm, input logic [65:0] want);
        logic [65:0] got;
        got = actual();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            logic [65:0] m;
            logic [65:0] got;
            cur = sb.pop_front();
            m   = cur.full ? {66{1'b1}} : {12'hFFF, 54'd0};
            got = actual();
            total++;
            if ((got & m) !== (cur.val & m)) begin
                bad++;
                $display("FAIL %s: got %h want %h", cur.name, got & m, cur.val & m);
            end
        end
    end

    localparam logic [7:0] C_LW   = 8'b0111_1000;
    localparam logic [7:0] C_RTYP = 8'b1001_0000;
    localparam logic [7:0] C_IMM  = 8'b0101_0000;

    instr_t z, lw8, lw0, lw9, addu_a, addu0, addu_b, addiu_a;
    instr_t multu_a, multu_b, maddu_a, mflo_a, mfhi_a;

    initial begin
        z       = mk(8'd0,   2'b00, 6'd0,     6'd0,   5'd0, 5'd0,  5'd0,  32'd0);
        lw8     = mk(C_LW,   2'b00, LW,       6'd0,   5'd9, 5'd8,  5'd0,  32'h1000_0001);
        lw0     = mk(C_LW,   2'b00, LW,       6'd0,   5'd9, 5'd0,  5'd0,  32'h1000_0002);
        lw9     = mk(C_LW,   2'b00, LW,       6'd0,   5'd8, 5'd9,  5'd0,  32'h1000_0003);
        addu_a  = mk(C_RTYP, 2'b10, R_FORMAT, 6'h21,  5'd8, 5'd9,  5'd10, 32'h2000_0001);
        addu0   = mk(C_RTYP, 2'b10, R_FORMAT, 6'h21,  5'd0, 5'd0,  5'd10, 32'h2000_0002);
        addu_b  = mk(C_RTYP, 2'b10, R_FORMAT, 6'h21,  5'd7, 5'd9,  5'd11, 32'h2000_0003);
        addiu_a = mk(C_IMM,  2'b00, ADDIU,    6'd0,   5'd9, 5'd12, 5'd0,  32'h3000_0001);
        multu_a = mk(8'd0,   2'b10, R_FORMAT, MULTU,  5'd8, 5'd9,  5'd0,  32'h4000_0001);
        multu_b = mk(8'd0,   2'b10, R_FORMAT, MULTU,  5'd3, 5'd4,  5'd0,  32'h4000_0002);
        maddu_a = mk(8'd0,   2'b10, MADDU,    6'd0,   5'd5, 5'd6,  5'd0,  32'h4000_0003);
        mflo_a  = mk(C_RTYP, 2'b10, R_FORMAT, MFLO,   5'd0, 5'd0,  5'd13, 32'h5000_0001);
        mfhi_a  = mk(C_RTYP, 2'b10, R_FORMAT, MFHI,   5'd0, 5'd0,  5'd14, 32'h5000_0002);

        rst = 1'b0;
        drive(lw8, 1'b0);
        #3;
        check_now("reset_async", pack(1'b0, 1'b0, z));
        repeat (2) @(posedge clk);
        #1;
        check_now("reset_held_over_edges", pack(1'b0, 1'b0, z));
        drive(z, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // load-use on rs
        step("lu_lw_issue",  lw8,    1'b0, 1'b0, 1'b0, z,      1'b1);
        step("lu_stall",     addu_a, 1'b0, 1'b1, 1'b0, lw8,    1'b1);
        step("lu_bubble",    addu_a, 1'b0, 1'b0, 1'b0, z,      1'b0);
        step("lu_addu_cap",  z,      1'b0, 1'b0, 1'b0, addu_a, 1'b1);
        // load into $zero never interlocks
        step("zero_lw",      lw0,    1'b0, 1'b0, 1'b0, z,      1'b1);
        step("zero_nostall", addu0,  1'b0, 1'b0, 1'b0, lw0,    1'b1);
        step("zero_cap",     z,      1'b0, 1'b0, 1'b0, addu0,  1'b1);
        // load-use on rt, flushed in the same cycle
        step("rt_lw",        lw9,    1'b0, 1'b0, 1'b0, z,      1'b1);
        step("flush_over_lu",addu_b, 1'b1, 1'b0, 1'b0, lw9,    1'b1);
        step("flush_bubble", z,      1'b0, 1'b0, 1'b0, z,      1'b0);
        // plain flush of a captured-candidate instruction
        step("addiu_issue",  addiu_a,1'b0, 1'b0, 1'b0, z,      1'b1);
        step("flush_issue",  addu_a, 1'b1, 1'b0, 1'b0, addiu_a,1'b1);
        step("flush_bub2",   z,      1'b0, 1'b0, 1'b0, z,      1'b0);
        step("after_flush",  z,      1'b0, 1'b0, 1'b0, z,      1'b1);

`ifdef MUL_INTERLOCK_EN
        // MULTU then MFLO: four busy cycles, MFLO held until release
        step("mul_issue",    multu_a,1'b0, 1'b0, 1'b0, z,      1'b1);
        step("mflo_stall0",  mflo_a, 1'b0, 1'b1, 1'b1, multu_a,1'b1);
        step("mflo_stall1",  mflo_a, 1'b0, 1'b1, 1'b1, z,      1'b0);
        step("mflo_stall2",  mflo_a, 1'b0, 1'b1, 1'b1, z,      1'b0);
        step("mflo_stall3",  mflo_a, 1'b0, 1'b1, 1'b1, z,      1'b0);
        step("mul_release",  mflo_a, 1'b0, 1'b0, 1'b0, z,      1'b0);
        step("mflo_cap",     z,      1'b0, 1'b0, 1'b0, mflo_a, 1'b1);
        // independent op proceeds; flush does not shorten the window; MADDU waits
        step("mul2_issue",   multu_b,1'b0, 1'b0, 1'b0, z,      1'b1);
        step("addiu_in_wait",addiu_a,1'b0, 1'b0, 1'b1, multu_b,1'b1);
        step("flush_in_wait",addu_a, 1'b1, 1'b0, 1'b1, addiu_a,1'b1);
        step("maddu_stall0", maddu_a,1'b0, 1'b1, 1'b1, z,      1'b0);
        step("maddu_stall1", maddu_a,1'b0, 1'b1, 1'b1, z,      1'b0);
        step("maddu_release",maddu_a,1'b0, 1'b0, 1'b0, z,      1'b0);
        step("maddu_cap",    z,      1'b0, 1'b0, 1'b1, maddu_a,1'b1);
        step("maddu_w1",     z,      1'b0, 1'b0, 1'b1, z,      1'b1);
        step("maddu_w2",     z,      1'b0, 1'b0, 1'b1, z,      1'b1);
        step("maddu_w3",     z,      1'b0, 1'b0, 1'b1, z,      1'b1);
        step("maddu_done",   z,      1'b0, 1'b0, 1'b0, z,      1'b1);
`else
        step("mul_issue",    multu_a,1'b0, 1'b0, 1'b0, z,      1'b1);
        step("mflo_nostall", mflo_a, 1'b0, 1'b0, 1'b0, multu_a,1'b1);
        step("mflo_cap",     z,      1'b0, 1'b0, 1'b0, mflo_a, 1'b1);
        step("mul2_issue",   multu_b,1'b0, 1'b0, 1'b0, z,      1'b1);
        step("addiu_in_wait",addiu_a,1'b0, 1'b0, 1'b0, multu_b,1'b1);
        step("flush_in_wait",addu_a, 1'b1, 1'b0, 1'b0, addiu_a,1'b1);
        step("maddu_nostall",maddu_a,1'b0, 1'b0, 1'b0, z,      1'b0);
        step("maddu_cap",    z,      1'b0, 1'b0, 1'b0, maddu_a,1'b1);
`endif

        // reset in the middle of a multiply window
        step("mul3_issue",   multu_a,1'b0, 1'b0, 1'b0,   z,       1'b1);
        step("mul3_w0",      z,      1'b0, 1'b0, MUL_ON, multu_a, 1'b1);
        step("mul3_w1",      z,      1'b0, 1'b0, MUL_ON, z,       1'b1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        drive(mfhi_a, 1'b0);
        #1;
        check_now("reset_mid_mul", pack(1'b0, 1'b0, z));
        @(posedge clk);
        #1;
        check_now("reset_mid_mul_held", pack(1'b0, 1'b0, z));
        @(negedge clk);
        rst = 1'b1;
        step("mfhi_cap",     z,      1'b0, 1'b0, 1'b0, mfhi_a, 1'b1);
        step("idle",         z,      1'b0, 1'b0, 1'b0, z,      1'b1);

        repeat (3) @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: pending=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
